// File: rtl/receptor_notas_buzzer_if.sv
// Note link between the game's output stage and the buzzer receiver.
// The master drives the note code and enable; the slave reports playback status.
interface receptor_notas_buzzer_if;
  logic [2:0] codigo;
  logic       enable;
  logic       buzzer;
  logic       tocando;
  logic [2:0] nota_atual;
  logic       pendente;
  logic       sobrescrita;

  modport master (
    output codigo,
    output enable,
    input  buzzer,
    input  tocando,
    input  nota_atual,
    input  pendente,
    input  sobrescrita
  );

  modport slave (
    input  codigo,
    input  enable,
    output buzzer,
    output tocando,
    output nota_atual,
    output pendente,
    output sobrescrita
  );
endinterface

// File: rtl/receptor_notas_buzzer.sv
// Note receiver: decodes 3-bit note codes into a timed square wave on a piezo
// buzzer, with a silent gap after each note and a one-deep pending buffer.
module receptor_notas_buzzer #(
  parameter int unsigned PRESC     = 50,
  parameter int unsigned DUR_TICKS = 250000,
  parameter int unsigned GAP_TICKS = 50000,
  parameter int unsigned CW        = 18
) (
  input logic                    clock,
  input logic                    reset,
  receptor_notas_buzzer_if.slave bus
);

  localparam int unsigned PW = (PRESC > 1) ? $clog2(PRESC) : 1;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    TOCANDO = 2'd1,
    PAUSA   = 2'd2
  } estado_t;

  estado_t       estado;
  estado_t       estado_n;

  logic [2:0]    codigo_prev;
  logic          enable_prev;
  logic [PW-1:0] presc_cnt;

  logic          tick_c;
  logic          evento_c;
  logic          consome_c;

  logic [CW-1:0] tom_cnt;
  logic [CW-1:0] tom_cnt_n;
  logic [CW-1:0] dur_cnt;
  logic [CW-1:0] dur_cnt_n;
  logic [CW-1:0] gap_cnt;
  logic [CW-1:0] gap_cnt_n;

  logic [2:0]    nota;
  logic [2:0]    nota_n;
  logic [2:0]    nota_pend;
  logic [2:0]    nota_pend_n;

  logic          buzzer_q;
  logic          buzzer_n;
  logic          pend_q;
  logic          pend_n;
  logic          sobr_q;
  logic          sobr_n;
  logic          tocando_q;

  // Half period of each note, in ticks; code 0 never plays.
  function automatic logic [CW-1:0] meio_periodo(input logic [2:0] c);
    logic [CW-1:0] r;
    case (c)
      3'd1:    r = CW'(1911);
      3'd2:    r = CW'(1703);
      3'd3:    r = CW'(1517);
      3'd4:    r = CW'(1432);
      3'd5:    r = CW'(1276);
      3'd6:    r = CW'(1136);
      3'd7:    r = CW'(1012);
      default: r = CW'(1);
    endcase
    return r;
  endfunction

  // Previous link values, used to spot new codes on the link.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      codigo_prev <= 3'd0;
      enable_prev <= 1'b0;
    end else begin
      codigo_prev <= bus.codigo;
      enable_prev <= bus.enable;
    end
  end

  // Free-running prescaler; only reset realigns the tick phase.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc_cnt <= '0;
    end else if (presc_cnt == PW'(PRESC - 1)) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + PW'(1);
    end
  end

  assign tick_c = (presc_cnt == PW'(PRESC - 1));

  // A held code counts once; code 0 is "no note".
  assign evento_c = bus.enable && (bus.codigo != 3'd0) &&
                    (!enable_prev || (bus.codigo != codigo_prev));

  // FSM state, counters and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado    <= OCIOSO;
      tom_cnt   <= '0;
      dur_cnt   <= '0;
      gap_cnt   <= '0;
      nota      <= 3'd0;
      nota_pend <= 3'd0;
      buzzer_q  <= 1'b0;
      pend_q    <= 1'b0;
      sobr_q    <= 1'b0;
      tocando_q <= 1'b0;
    end else begin
      estado    <= estado_n;
      tom_cnt   <= tom_cnt_n;
      dur_cnt   <= dur_cnt_n;
      gap_cnt   <= gap_cnt_n;
      nota      <= nota_n;
      nota_pend <= nota_pend_n;
      buzzer_q  <= buzzer_n;
      pend_q    <= pend_n;
      sobr_q    <= sobr_n;
      tocando_q <= (estado_n == TOCANDO);
    end
  end

  // Next state: play, pause, chain the pending note; park new notes while busy.
  always_comb begin
    estado_n    = estado;
    tom_cnt_n   = tom_cnt;
    dur_cnt_n   = dur_cnt;
    gap_cnt_n   = gap_cnt;
    nota_n      = nota;
    nota_pend_n = nota_pend;
    buzzer_n    = buzzer_q;
    pend_n      = pend_q;
    sobr_n      = 1'b0;
    consome_c   = 1'b0;

    unique case (estado)
      OCIOSO: begin
        buzzer_n = 1'b0;
        nota_n   = 3'd0;
        if (evento_c) begin
          nota_n    = bus.codigo;
          tom_cnt_n = '0;
          dur_cnt_n = '0;
          buzzer_n  = 1'b1;
          estado_n  = TOCANDO;
        end
      end

      TOCANDO: begin
        if (tick_c) begin
          if (dur_cnt == CW'(DUR_TICKS - 1)) begin
            estado_n  = PAUSA;
            buzzer_n  = 1'b0;
            dur_cnt_n = '0;
            tom_cnt_n = '0;
            gap_cnt_n = '0;
          end else begin
            dur_cnt_n = dur_cnt + CW'(1);
            if (tom_cnt == (meio_periodo(nota) - CW'(1))) begin
              buzzer_n  = ~buzzer_q;
              tom_cnt_n = '0;
            end else begin
              tom_cnt_n = tom_cnt + CW'(1);
            end
          end
        end
      end

      PAUSA: begin
        buzzer_n = 1'b0;
        if (tick_c) begin
          if (gap_cnt == CW'(GAP_TICKS - 1)) begin
            gap_cnt_n = '0;
            if (pend_q) begin
              consome_c = 1'b1;
              nota_n    = nota_pend;
              pend_n    = 1'b0;
              tom_cnt_n = '0;
              dur_cnt_n = '0;
              buzzer_n  = 1'b1;
              estado_n  = TOCANDO;
            end else begin
              nota_n   = 3'd0;
              estado_n = OCIOSO;
            end
          end else begin
            gap_cnt_n = gap_cnt + CW'(1);
          end
        end
      end

      default: begin
        estado_n = OCIOSO;
        buzzer_n = 1'b0;
        nota_n   = 3'd0;
      end
    endcase

    // Busy: newest note wins the buffer; a same-cycle consume frees it first.
    // A note parked on the final gap cycle waits for the next gap end.
    if (evento_c && (estado != OCIOSO)) begin
      nota_pend_n = bus.codigo;
      pend_n      = 1'b1;
      sobr_n      = pend_q && !consome_c;
    end
  end

  assign bus.buzzer      = buzzer_q;
  assign bus.tocando     = tocando_q;
  assign bus.nota_atual  = nota;
  assign bus.pendente    = pend_q;
  assign bus.sobrescrita = sobr_q;

endmodule

// File: tb/tb_receptor_notas_buzzer.sv
// Bench for receptor_notas_buzzer: timestamp-based note model feeding a
// per-cycle expectation queue, drained by an independent output monitor.
module tb_receptor_notas_buzzer;

  localparam int unsigned DUR = 8000;
  localparam int unsigned GAP = 100;

  typedef struct packed {
    logic       buzzer;
    logic       tocando;
    logic [2:0] nota;
    logic       pendente;
    logic       sobrescrita;
  } exp_t;

  logic clock;
  logic reset;

  receptor_notas_buzzer_if bus ();

  receptor_notas_buzzer #(
    .PRESC    (1),
    .DUR_TICKS(DUR),
    .GAP_TICKS(GAP),
    .CW       (18)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t exp_q[$];

  // Reference model state: notes described by start edge and end-of-gap edge.
  int unsigned k = 0;
  logic        m_active = 1'b0;
  int unsigned m_start = 0;
  int unsigned m_end = 0;
  logic [2:0]  m_cur = 3'd0;
  logic        m_pend_v = 1'b0;
  logic [2:0]  m_pend = 3'd0;
  logic        m_prev_en = 1'b0;
  logic [2:0]  m_prev_cod = 3'd0;
  int          m_notes = 0;
  int          m_ovw = 0;

  int          dut_notes = 0;
  int          dut_ovw = 0;
  logic        toc_prev = 1'b0;

  function automatic int unsigned hp(input logic [2:0] c);
    case (c)
      3'd1:    return 1911;
      3'd2:    return 1703;
      3'd3:    return 1517;
      3'd4:    return 1432;
      3'd5:    return 1276;
      3'd6:    return 1136;
      3'd7:    return 1012;
      default: return 1;
    endcase
  endfunction

  task automatic start_note(input logic [2:0] c, input int unsigned at);
    m_active = 1'b1;
    m_start  = at;
    m_cur    = c;
    m_end    = at + DUR + GAP;
    m_notes++;
  endtask

  // Model: one step per clock edge, pushes the expected outputs after that edge.
  always @(posedge clock) begin : ref_model
    logic ev;
    logic busy_before;
    logic ov;
    exp_t x;
    k  = k + 1;
    ov = 1'b0;
    if (reset) begin
      m_active   = 1'b0;
      m_pend_v   = 1'b0;
      m_prev_en  = 1'b0;
      m_prev_cod = 3'd0;
    end else begin
      ev = bus.enable && (bus.codigo != 3'd0) &&
           (!m_prev_en || (bus.codigo != m_prev_cod));
      m_prev_en   = bus.enable;
      m_prev_cod  = bus.codigo;
      busy_before = m_active && (k <= m_end);
      if (m_active && (k == m_end)) begin
        if (m_pend_v) begin
          start_note(m_pend, k);
          m_pend_v = 1'b0;
        end else begin
          m_active = 1'b0;
        end
      end
      if (ev) begin
        if (busy_before) begin
          ov       = m_pend_v;
          m_pend   = bus.codigo;
          m_pend_v = 1'b1;
        end else begin
          start_note(bus.codigo, k);
        end
      end
    end
    if (ov) m_ovw++;
    x = '0;
    if (m_active && (k < m_start + DUR)) begin
      x.tocando = 1'b1;
      x.nota    = m_cur;
      x.buzzer  = ((((k - m_start) / hp(m_cur)) % 2) == 0);
    end else if (m_active && (k < m_end)) begin
      x.nota = m_cur;
    end
    x.pendente    = m_pend_v;
    x.sobrescrita = ov;
    exp_q.push_back(x);
  end

  // Monitor: compares DUT outputs mid-cycle; while reset is high all must be 0.
  always @(negedge clock) begin : monitor
    exp_t x;
    exp_t a;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      if (reset) x = '0;
      a = {bus.buzzer, bus.tocando, bus.nota_atual, bus.pendente, bus.sobrescrita};
      n_checks++;
      if (a !== x) begin
        n_fail++;
        $display("FAIL outputs edge=%0d got buz=%b toc=%b nota=%0d pend=%b sob=%b want buz=%b toc=%b nota=%0d pend=%b sob=%b",
                 k, a.buzzer, a.tocando, a.nota, a.pendente, a.sobrescrita,
                 x.buzzer, x.tocando, x.nota, x.pendente, x.sobrescrita);
      end
      if (bus.tocando === 1'b1 && toc_prev === 1'b0) dut_notes++;
      if (bus.sobrescrita === 1'b1) dut_ovw++;
      toc_prev = bus.tocando;
      if (n_fail >= 50) begin
        $display("FAIL abort: too many output differences, stopping early");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
      end
    end
  end

  task automatic drive(input logic en, input logic [2:0] c);
    @(posedge clock);
    #1;
    bus.enable = en;
    bus.codigo = c;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 3'd0);
  endtask

  task automatic check_count(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  initial begin : stimulus
    logic       re;
    logic [2:0] rc;
    int         guard;
    reset      = 1'b1;
    bus.enable = 1'b0;
    bus.codigo = 3'd0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Single note C, then full duration and gap.
    drive(1'b1, 3'd1);
    idle(8200);

    // Disabled link or code 0: no note.
    for (int i = 0; i < 5; i++) drive(1'b0, 3'd4);
    for (int i = 0; i < 5; i++) drive(1'b1, 3'd0);

    // Held code is a single event.
    for (int i = 0; i < 9000; i++) drive(1'b1, 3'd5);
    idle(10);

    // Two notes during note E: the later one overwrites.
    drive(1'b1, 3'd3);
    idle(100);
    drive(1'b1, 3'd6);
    idle(100);
    drive(1'b1, 3'd7);
    idle(16300);

    // New event on the exact edge the gap ends with a note pending.
    drive(1'b1, 3'd2);
    idle(50);
    drive(1'b1, 3'd4);
    guard = 0;
    while ((k + 2 < m_end) && (guard < 20000)) begin
      drive(1'b0, 3'd0);
      guard++;
    end
    check_count("gap_end_wait_bound", (guard < 20000) ? 1 : 0, 1);
    drive(1'b1, 3'd6);
    idle(300);

    // Reset mid-note with a note pending, then a clean restart.
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    drive(1'b1, 3'd1);
    idle(8200);

    // Random link activity.
    re = 1'b0;
    rc = 3'd0;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        re = ($urandom_range(0, 3) != 0);
        rc = 3'($urandom_range(0, 7));
      end
      drive(re, rc);
    end
    guard = 0;
    while (m_active && (k <= m_end) && (guard < 20000)) begin
      drive(1'b0, 3'd0);
      guard++;
    end
    check_count("drain_bound", (guard < 20000) ? 1 : 0, 1);
    idle(5);

    check_count("notes_started", dut_notes, m_notes);
    check_count("overwrite_pulses", dut_ovw, m_ovw);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
